riscv_multicycle_control: RTL and testbench

//  Multicycle control FSM that drives the RISC-V simple datapath's control inputs.
//  - Fetches an instruction over a valid-qualified handshake and holds it in an

---
 rtl/riscv_multicycle_control.sv | 120 ++++++++++++
 tb/tb_riscv_multicycle_control.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_control.sv
// Multicycle RISC-V control FSM: fetch handshake, IF/ID/EX/MEM/WB sequencing, retire count.
// Moore strobes from state + instr_q; only the store completion strobe looks at dValid.
module riscv_multicycle_control #(
  parameter int          RETIRE_W  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  output logic                iMemRead,
  input  logic                iValid,
  input  logic [31:0]         iData,
  output logic [31:0]         instr_q,
  input  logic                Zero,
  output logic                ALUSrc,
  output logic [3:0]          ALUCtrl,
  output logic                PCSrc,
  output logic                loadPC,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                MemRead,
  output logic                MemWrite,
  input  logic                dValid,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  logic [2:0]          state_q, state_d;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retired_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       f3_ok, legal, retire;
  logic [3:0] alu_f3, dec_alu;

  // Zero is observed by the datapath only; the branch mux is gated there.
  logic zero_unused;
  assign zero_unused = Zero;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign f7b5   = instr_q[30];
  assign is_r   = (opcode == 7'b0110011);
  assign is_i   = (opcode == 7'b0010011);
  assign is_ld  = (opcode == 7'b0000011);
  assign is_st  = (opcode == 7'b0100011);
  assign is_br  = (opcode == 7'b1100011);

  always_comb begin
    alu_f3 = 4'b0010;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = (is_r && f7b5) ? 4'b0110 : 4'b0010;
      3'b001:  alu_f3 = 4'b1001;
      3'b010:  alu_f3 = 4'b0111;
      3'b100:  alu_f3 = 4'b1101;
      3'b101:  alu_f3 = f7b5 ? 4'b1010 : 4'b1000;
      3'b110:  alu_f3 = 4'b0001;
      3'b111:  alu_f3 = 4'b0000;
      default: f3_ok  = 1'b0;
    endcase
  end

  assign dec_alu = (is_r || is_i) ? alu_f3 : (is_br ? 4'b0110 : 4'b0010);
  assign legal   = ((is_r || is_i) && f3_ok) || is_ld || is_st || (is_br && funct3 == 3'b000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:    if (iValid) state_d = S_ID;
      S_ID:    state_d = legal ? S_EX : S_HALT;
      S_EX:    state_d = is_br ? S_IF : ((is_ld || is_st) ? S_MEM : S_WB);
      S_MEM:   if (dValid) state_d = is_ld ? S_WB : S_IF;
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // A retire is exactly the cycle the PC is updated.
  assign retire = (state_q == S_EX && is_br) || (state_q == S_WB) ||
                  (state_q == S_MEM && is_st && dValid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      instr_q   <= NOP_INSTR;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF && iValid) instr_q <= iData;
      if (state_q == S_ID && !legal) illegal_q <= 1'b1;
      if (retire) retired_q <= retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  // Everything combinational is forced low while reset is held.
  assign iMemRead = !rst && (state_q == S_IF);
  assign ALUSrc   = !rst && (is_i || is_ld || is_st);
  assign ALUCtrl  = rst ? 4'b0000 : dec_alu;
  assign PCSrc    = !rst && (state_q == S_EX) && is_br;
  assign loadPC   = !rst && retire;
  assign RegWrite = !rst && (state_q == S_WB);
  assign MemtoReg = !rst && (state_q == S_WB) && is_ld;
  assign MemRead  = !rst && (state_q == S_MEM) && is_ld;
  assign MemWrite = !rst && (state_q == S_MEM) && is_st;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Randomized bench for riscv_multicycle_control: per-instruction cycle traces from a
// decode table, compared against the DUT every cycle, plus directed literal checks.
module tb_riscv_multicycle_control;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          iMemRead, iValid, Zero, ALUSrc, PCSrc, loadPC, RegWrite, MemtoReg;
  logic          MemRead, MemWrite, dValid, illegal;
  logic [31:0]   iData, instr_q;
  logic [3:0]    ALUCtrl;
  logic [RW-1:0] retired;

  riscv_multicycle_control #(.RETIRE_W(RW), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .iMemRead(iMemRead), .iValid(iValid), .iData(iData),
    .instr_q(instr_q), .Zero(Zero), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .PCSrc(PCSrc),
    .loadPC(loadPC), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .dValid(dValid), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // instruction classes
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_BAD = 5;

  typedef struct { bit legal; int cls; logic [3:0] alu; bit src; } dec_t;
  typedef struct {
    bit imr, src, pcs, lpc, rw, m2r, mr, mw, ill, alu_care;
    logic [3:0] alu; int ret; logic [31:0] ins;
  } exp_t;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_instr = 32'h13;
  int          m_ret = 0;
  bit          m_ill = 0;
  int          n_step = 0, abort_at = -1;

  function automatic dec_t dec(input logic [31:0] ins);
    dec_t d;
    logic [3:0] tbl [8];
    logic [2:0] f3;
    tbl = '{4'b0010, 4'b1001, 4'b0111, 4'b0000, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
    f3 = ins[14:12];
    d.legal = 1; d.alu = 4'b0010; d.src = 0;
    case (ins[6:0])
      7'h33:   d.cls = C_R;
      7'h13:   d.cls = C_I;
      7'h03:   d.cls = C_LD;
      7'h23:   d.cls = C_ST;
      7'h63:   d.cls = C_BR;
      default: d.cls = C_BAD;
    endcase
    if (d.cls == C_R || d.cls == C_I) begin
      d.alu = tbl[f3];
      if (f3 == 3'd0 && d.cls == C_R && ins[30]) d.alu = 4'b0110;
      if (f3 == 3'd5 && ins[30]) d.alu = 4'b1010;
      if (f3 == 3'd3) d.legal = 0;
    end
    if (d.cls == C_BR) begin d.alu = 4'b0110; d.legal = (f3 == 3'd0); end
    if (d.cls == C_BAD) d.legal = 0;
    d.src = (d.cls == C_I || d.cls == C_LD || d.cls == C_ST);
    return d;
  endfunction

  function automatic exp_t base(input dec_t d);
    exp_t e;
    e = '{default: 0};
    e.alu = d.alu; e.src = d.src; e.alu_care = d.legal;
    e.ill = m_ill; e.ret = m_ret; e.ins = m_instr;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic cmp_all(input exp_t e);
    chk("iMemRead", 32'(iMemRead), 32'(e.imr));
    chk("PCSrc",    32'(PCSrc),    32'(e.pcs));
    chk("loadPC",   32'(loadPC),   32'(e.lpc));
    chk("RegWrite", 32'(RegWrite), 32'(e.rw));
    chk("MemtoReg", 32'(MemtoReg), 32'(e.m2r));
    chk("MemRead",  32'(MemRead),  32'(e.mr));
    chk("MemWrite", 32'(MemWrite), 32'(e.mw));
    chk("illegal",  32'(illegal),  32'(e.ill));
    chk("retired",  32'(retired),  32'(e.ret));
    chk("instr_q",  instr_q,       e.ins);
    if (e.alu_care) begin
      chk("ALUCtrl", 32'(ALUCtrl), 32'(e.alu));
      chk("ALUSrc",  32'(ALUSrc),  32'(e.src));
    end
  endtask

  task automatic cyc(input bit iv, input bit dv, input logic [31:0] id, input exp_t e);
    @(posedge clk);
    #1;
    iValid = iv; dValid = dv; iData = id; Zero = 1'($urandom);
    @(negedge clk);
    cmp_all(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    iValid = 0; dValid = 0;
    #2 rst = 1;
    #1;
    chk("rst_iMemRead", 32'(iMemRead), 0);
    chk("rst_strobes", 32'({PCSrc, loadPC, RegWrite, MemtoReg, MemRead, MemWrite}), 0);
    chk("rst_alu", 32'({ALUSrc, ALUCtrl}), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_instr_q", instr_q, 32'h0000_0013);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_release_iMemRead", 32'(iMemRead), 1);
    m_instr = 32'h13; m_ret = 0; m_ill = 0; abort_at = -1;
  endtask

  task automatic step(input bit iv, input bit dv, input logic [31:0] id, input exp_t e,
                      output bit ab);
    if (abort_at == n_step) begin
      do_reset();
      ab = 1;
    end else begin
      cyc(iv, dv, id, e);
      ab = 0;
    end
    n_step++;
  endtask

  // One instruction: iw fetch waits, dw data waits, spur = noise on ignored inputs.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input bit spur,
                           input int halt_cycles);
    dec_t d;
    exp_t e;
    bit   ab, sp1, sp2;
    n_step = 0;
    d = dec(m_instr);
    for (int k = 0; k <= iw; k++) begin
      e = base(d); e.imr = 1;
      sp1 = spur & 1'($urandom);
      step(k == iw, sp1, (k == iw) ? ins : $urandom, e, ab);
      if (ab) return;
    end
    m_instr = ins;
    d = dec(ins);
    sp1 = spur & 1'($urandom); sp2 = spur & 1'($urandom);
    step(sp1, sp2, $urandom, base(d), ab);
    if (ab) return;
    if (!d.legal) begin
      m_ill = 1;
      for (int k = 0; k < halt_cycles; k++) begin
        sp1 = 1'($urandom); sp2 = 1'($urandom);
        step(sp1, sp2, $urandom, base(d), ab);
        if (ab) return;
      end
      return;
    end
    e = base(d);
    if (d.cls == C_BR) begin e.pcs = 1; e.lpc = 1; end
    sp1 = spur & 1'($urandom); sp2 = spur & 1'($urandom);
    step(sp1, sp2, $urandom, e, ab);
    if (ab) return;
    if (d.cls == C_BR) begin m_ret = (m_ret + 1) % 16; return; end
    if (d.cls == C_LD || d.cls == C_ST) begin
      for (int k = 0; k <= dw; k++) begin
        e = base(d);
        e.mr = (d.cls == C_LD); e.mw = (d.cls == C_ST);
        e.lpc = (d.cls == C_ST) && (k == dw);
        sp1 = spur & 1'($urandom);
        step(sp1, k == dw, $urandom, e, ab);
        if (ab) return;
      end
      if (d.cls == C_ST) begin m_ret = (m_ret + 1) % 16; return; end
    end
    e = base(d);
    e.rw = 1; e.lpc = 1; e.m2r = (d.cls == C_LD);
    sp1 = spur & 1'($urandom); sp2 = spur & 1'($urandom);
    step(sp1, sp2, $urandom, e, ab);
    if (ab) return;
    m_ret = (m_ret + 1) % 16;
  endtask

  // Idle IF cycle with literal expectations.
  task automatic lit_if(input string nm, input logic [3:0] alu, input bit src, input int ret,
                        input logic [31:0] ins);
    @(posedge clk);
    #1 iValid = 0; dValid = 0;
    @(negedge clk);
    chk({nm, "_iMemRead"}, 32'(iMemRead), 1);
    chk({nm, "_ALUCtrl"}, 32'(ALUCtrl), 32'(alu));
    chk({nm, "_ALUSrc"}, 32'(ALUSrc), 32'(src));
    chk({nm, "_retired"}, 32'(retired), 32'(ret));
    chk({nm, "_instr_q"}, instr_q, ins);
  endtask

  function automatic logic [31:0] rnd_instr(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      C_R:  begin r[6:0] = 7'h33; r[31:25] = r[30] ? 7'h20 : 7'h00; if (r[14:12] == 3'd3) r[14:12] = 3'd0; end
      C_I:  begin r[6:0] = 7'h13; if (r[14:12] == 3'd3) r[14:12] = 3'd7; end
      C_LD: r[6:0] = 7'h03;
      C_ST: r[6:0] = 7'h23;
      C_BR: begin r[6:0] = 7'h63; r[14:12] = 3'd0; end
      default: begin
        case ($urandom_range(0, 2))
          0: r[6:0] = 7'h7F;
          1: begin r[6:0] = 7'h33; r[14:12] = 3'd3; end
          default: begin r[6:0] = 7'h63; r[14:12] = 3'd1; end
        endcase
      end
    endcase
    return r;
  endfunction

  initial begin
    iValid = 0; dValid = 0; iData = '0; Zero = 0;
    do_reset();

    run_instr(32'h002081B3, 0, 0, 0, 0);
    lit_if("add", 4'b0010, 0, 1, 32'h002081B3);

    run_instr(32'h00812283, 0, 2, 0, 0);
    lit_if("lw", 4'b0010, 1, 2, 32'h00812283);

    run_instr(32'h00512423, 0, 0, 0, 0);
    run_instr(32'h00208463, 0, 0, 0, 0);
    lit_if("beq", 4'b0110, 0, 4, 32'h00208463);

    run_instr(32'h0000007F, 0, 0, 0, 20);
    chk("halt_illegal", 32'(illegal), 1);
    do_reset();

    // reset while MemRead is held, before dValid arrives
    abort_at = 5;
    run_instr(32'h00812283, 0, 4, 0, 0);
    chk("abort_retired", 32'(retired), 0);

    for (int k = 0; k < 16; k++)
      run_instr({$urandom_range(0, 4095), 5'd0, 3'd0, 5'd0, 7'h13} & 32'hFFF0_0FFF | 32'h13, 0, 0, 1, 0);
    lit_if("wrap", 4'b0010, 1, 0, m_instr);

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 29) == 0 ? C_BAD : $urandom_range(0, 4);
      if ($urandom_range(0, 24) == 0) abort_at = $urandom_range(0, 8);
      run_instr(rnd_instr(kind), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                $urandom_range(1, 6));
      if (m_ill) do_reset();
      abort_at = -1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
